// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared config type, sanitising rules and defaults for clock_divider_array
//
// Contents:
//   CFG_W        internal width of every period/high/phase/counter value
//   clk_cfg_t    one channel configuration (period, high time, phase)
//   sanitize()   clamps a raw configuration into a safe one
//   default_cfg  builds the reset configuration for a given period
//   DEFAULT_CFG  reset configuration for the nominal 100 MHz / 1 Hz case

package clock_divider_pkg;

    // All per-channel arithmetic is done at this width; top-level WIDTH
    // must not exceed it.
    localparam int CFG_W = 32;

    localparam logic [CFG_W-1:0] MIN_PERIOD = CFG_W'(2);

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } clk_cfg_t;

    // period below 2 would make the wrap compare degenerate, so it is raised
    // to 2. A phase outside the (clamped) period restarts at 0. high needs no
    // clamp: 0 compares false forever and >= period compares true forever,
    // which gives the constant-low / constant-high behaviour directly.
    function automatic clk_cfg_t sanitize(input clk_cfg_t raw);
        clk_cfg_t c;
        c = raw;
        if (raw.period < MIN_PERIOD) begin
            c.period = MIN_PERIOD;
        end
        if (raw.phase >= c.period) begin
            c.phase = '0;
        end
        return c;
    endfunction

    function automatic clk_cfg_t default_cfg(input logic [CFG_W-1:0] period);
        clk_cfg_t c;
        c.period = period;
        c.high   = period >> 1;
        c.phase  = '0;
        return sanitize(c);
    endfunction

    localparam clk_cfg_t DEFAULT_CFG = '{
        period: CFG_W'(100_000_000),
        high:   CFG_W'(50_000_000),
        phase:  '0
    };

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one programmable divider channel with shadowed config
//
// Ports:
//   clk_i        sole clock
//   reset_n_i    synchronous active-low reset
//   enable_i     run enable; rising edge restarts at phase, low holds cnt at 0
//   sync_i       one-cycle restart strobe (ignored while disabled)
//   cfg_we_i     config write strobe; taken only while no shadow is pending
//   cfg_period_i raw period (sanitised on accept)
//   cfg_high_i   raw high time
//   cfg_phase_i  raw start count
//   pending_o    shadow config staged but not yet active
//   clock_o      registered divided clock
//   rise_o       strobe in the first cycle clock_o is high
//   fall_o       strobe in the first cycle clock_o is low

module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int DEFAULT_PERIOD = 100_000_000
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [CFG_W-1:0] cfg_period_i,
    input  logic [CFG_W-1:0] cfg_high_i,
    input  logic [CFG_W-1:0] cfg_phase_i,
    output logic             pending_o,
    output logic             clock_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam clk_cfg_t RST_CFG = default_cfg(CFG_W'(DEFAULT_PERIOD));

    clk_cfg_t         active_q, active_d;
    clk_cfg_t         shadow_q, shadow_d;
    clk_cfg_t         cfg_use;
    clk_cfg_t         cfg_raw;
    logic             pending_q, pending_d;
    logic [CFG_W-1:0] cnt_q, cnt_d;
    logic             clock_q, clock_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             en_q;

    logic             en_rise;
    logic             restart;
    logic             wrap;
    logic             apply;

    always_comb begin
        cfg_raw.period = cfg_period_i;
        cfg_raw.high   = cfg_high_i;
        cfg_raw.phase  = cfg_phase_i;

        en_rise = enable_i & ~en_q;
        // sync only restarts a channel that stays enabled; a simultaneous
        // disable takes priority because enable_i gates it here.
        restart = enable_i & (en_rise | sync_i);
        // >= rather than == keeps the counter bounded even if cnt ever sits
        // outside the active period.
        wrap    = (cnt_q >= (active_q.period - CFG_W'(1)));

        // The shadow is swapped in at any point where the counter restarts
        // anyway (wrap, sync, enable edge) or when nothing is running.
        apply   = pending_q & (~enable_i | restart | wrap);
        cfg_use = apply ? shadow_q : active_q;

        active_d  = cfg_use;
        shadow_d  = shadow_q;
        pending_d = pending_q & ~apply;

        // apply requires pending_q, and accept requires ~pending_q, so the
        // two never collide.
        if (cfg_we_i && !pending_q) begin
            shadow_d  = sanitize(cfg_raw);
            pending_d = 1'b1;
        end

        if (!enable_i) begin
            cnt_d = '0;
        end else if (restart) begin
            cnt_d = cfg_use.phase;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CFG_W'(1);
        end

        // The level is computed from the counter value it will be held with,
        // so clock_o always matches cnt_q in the same cycle.
        clock_d = enable_i & (cnt_d < cfg_use.high);
        rise_d  = clock_d & ~clock_q;
        fall_d  = ~clock_d & clock_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            active_q  <= RST_CFG;
            shadow_q  <= RST_CFG;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            clock_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            clock_q   <= clock_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            en_q      <= enable_i;
        end
    end

    assign pending_o = pending_q;
    assign clock_o   = clock_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule

// File: rtl/clock_divider_array.sv
// rtl/clock_divider_array.sv - NCH-channel programmable clock/pulse generator
//
// Parameters:
//   NCH            channel count, 1..16
//   WIDTH          period/high/phase width (<= clock_divider_pkg::CFG_W)
//   DEFAULT_PERIOD reset period; reset high = DEFAULT_PERIOD/2, phase = 0
//   CHW            channel-select width (derived, minimum 1)
//
// Ports:
//   clk        sole clock
//   reset_n    synchronous active-low reset
//   enable     per-channel run enable
//   sync       restart all enabled channels at their phase
//   cfg_valid  config write request
//   cfg_ready  config accepted when valid && ready (combinational on cfg_ch)
//   cfg_ch     target channel
//   cfg_period period in clk cycles
//   cfg_high   high time in clk cycles
//   cfg_phase  start count used on enable or sync
//   pending    per-channel staged-config flag
//   clock      per-channel divided clock, registered
//   rise/fall  per-channel edge strobes, registered

module clock_divider_array
    import clock_divider_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int WIDTH          = 32,
    parameter int DEFAULT_PERIOD = 100_000_000,
    parameter int CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   enable,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic [WIDTH-1:0] cfg_phase,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   clock,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall
);

    // Selects beyond NCH (non-power-of-two NCH) read as "not pending":
    // such writes are accepted and land nowhere rather than stalling.
    localparam int NPAD = 1 << CHW;

    logic [NPAD-1:0]  pending_pad;
    logic [CFG_W-1:0] period_w;
    logic [CFG_W-1:0] high_w;
    logic [CFG_W-1:0] phase_w;

    assign period_w = CFG_W'(cfg_period);
    assign high_w   = CFG_W'(cfg_high);
    assign phase_w  = CFG_W'(cfg_phase);

    always_comb begin
        pending_pad          = '0;
        pending_pad[NCH-1:0] = pending;
        cfg_ready            = ~pending_pad[cfg_ch];
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic cfg_we;

        // The channel itself refuses writes while pending, which is exactly
        // the cfg_ready condition for this channel.
        assign cfg_we = cfg_valid & (cfg_ch == CHW'(i));

        clock_divider_channel #(
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk_i        (clk),
            .reset_n_i    (reset_n),
            .enable_i     (enable[i]),
            .sync_i       (sync),
            .cfg_we_i     (cfg_we),
            .cfg_period_i (period_w),
            .cfg_high_i   (high_w),
            .cfg_phase_i  (phase_w),
            .pending_o    (pending[i]),
            .clock_o      (clock[i]),
            .rise_o       (rise[i]),
            .fall_o       (fall[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_array.sv
// tb/tb_clock_divider_array.sv - directed self-checking bench for clock_divider_array

module tb_clock_divider_array;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;
    localparam int CHW   = 2;
    localparam int DEFP  = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   enable;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic [WIDTH-1:0] cfg_phase;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   clock;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_divider_array #(
        .NCH            (NCH),
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFP),
        .CHW            (CHW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sync       (sync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .pending    (pending),
        .clock      (clock),
        .rise       (rise),
        .fall       (fall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int ch, input int p, input int h, input int ph);
        cfg_valid  = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = WIDTH'(p);
        cfg_high   = WIDTH'(h);
        cfg_phase  = WIDTH'(ph);
        tick();
        cfg_valid  = 1'b0;
    endtask

    // Checks n consecutive cycles starting with the current one; the first
    // expected cycle is the most significant of the n bits.
    task automatic expect_wave(input int ch, input string tag, input int n,
                               input logic [31:0] ec, input logic [31:0] er,
                               input logic [31:0] ef);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_clk%0d", tag, i),  32'(clock[ch]), 32'(ec[n-1-i]));
            check($sformatf("%s_rise%0d", tag, i), 32'(rise[ch]),  32'(er[n-1-i]));
            check($sformatf("%s_fall%0d", tag, i), 32'(fall[ch]),  32'(ef[n-1-i]));
            tick();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = '0;
        sync       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_phase  = '0;
        tick();
        tick();
        check("rst_clock",   32'(clock),     0);
        check("rst_rise",    32'(rise),      0);
        check("rst_fall",    32'(fall),      0);
        check("rst_pending", 32'(pending),   0);
        check("rst_ready",   32'(cfg_ready), 1);
        reset_n = 1'b1;

        // ch0: period 10, high 3, phase 0
        write_cfg(0, 10, 3, 0);
        check("t1_pend_set", 32'(pending), 32'h1);
        tick();
        check("t1_pend_clr", 32'(pending), 0);
        enable = 4'b0001;
        tick();
        expect_wave(0, "t1", 20, 20'b1110000000_1110000000,
                    20'b1000000000_1000000000, 20'b0001000000_0001000000);

        // drop enable while high: single fall, then held low
        enable = 4'b0000;
        tick();
        check("dis_clock", 32'(clock[0]), 0);
        check("dis_fall",  32'(fall[0]),  1);
        tick();
        check("dis_fall2",  32'(fall[0]),  0);
        check("dis_clock2", 32'(clock[0]), 0);

        // re-enable with phase 2, high 3
        write_cfg(0, 10, 3, 2);
        tick();
        enable = 4'b0001;
        tick();
        expect_wave(0, "reen", 13, 13'b1000000011100, 13'b1000000010000, 13'b0100000000010);
        enable = 4'b0000;
        tick();
        tick();

        // ch1: 8/4 then a mid-period rewrite to 6/1
        write_cfg(1, 8, 4, 0);
        tick();
        enable = 4'b0010;
        tick();
        check("t2_start_clk",  32'(clock[1]), 1);
        check("t2_start_rise", 32'(rise[1]),  1);
        tick();
        tick();
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = 16'd6;
        cfg_high   = 16'd1;
        cfg_phase  = 16'd0;
        #1;
        check("t2_ready_pre", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        check("t2_pend",     32'(pending[1]), 1);
        check("t2_ready_lo", 32'(cfg_ready),  0);
        expect_wave(1, "t2a", 4, 4'b1000, 4'b0000, 4'b0100);
        check("t2_pend_c7",  32'(pending[1]), 1);
        check("t2_ready_c7", 32'(cfg_ready),  0);
        expect_wave(1, "t2b", 9, 9'b010000010, 9'b010000010, 9'b001000001);
        check("t2_pend_end",  32'(pending[1]), 0);
        check("t2_ready_end", 32'(cfg_ready),  1);
        enable = 4'b0000;
        tick();
        tick();

        // ch2/ch3: period 8, high 4, phases 0 and 4, then sync
        write_cfg(2, 8, 4, 0);
        write_cfg(3, 8, 4, 4);
        tick();
        check("t3_pend", 32'(pending), 0);
        enable = 4'b1100;
        tick();
        repeat (5) tick();
        check("t3_pre_ch2", 32'(clock[2]), 0);
        check("t3_pre_ch3", 32'(clock[3]), 1);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("t3_ch2_clk",  32'(clock[2]), 1);
        check("t3_ch2_rise", 32'(rise[2]),  1);
        check("t3_ch0_off",  32'(clock[0]), 0);
        expect_wave(3, "t3", 5, 5'b00001, 5'b00001, 5'b10000);
        enable = 4'b0000;
        tick();
        tick();

        // edge configs on ch1
        write_cfg(1, 1, 1, 0);
        tick();
        enable = 4'b0010;
        tick();
        expect_wave(1, "p1", 4, 4'b1010, 4'b1010, 4'b0101);
        enable = 4'b0000;
        tick();
        tick();

        write_cfg(1, 10, 0, 0);
        tick();
        enable = 4'b0010;
        tick();
        expect_wave(1, "h0", 12, 0, 0, 0);
        enable = 4'b0000;
        tick();
        tick();

        write_cfg(1, 10, 12, 0);
        tick();
        enable = 4'b0010;
        tick();
        expect_wave(1, "h12", 12, 12'hFFF, 12'h800, 0);
        enable = 4'b0000;
        tick();
        check("h12_dis_fall", 32'(fall[1]),  1);
        check("h12_dis_clk",  32'(clock[1]), 0);
        tick();

        write_cfg(1, 10, 3, 15);
        tick();
        enable = 4'b0010;
        tick();
        expect_wave(1, "ph15", 4, 4'b1110, 4'b1000, 4'b0001);
        enable = 4'b0000;
        tick();
        tick();

        // reset mid-pulse with a staged config
        write_cfg(0, 10, 3, 0);
        tick();
        enable = 4'b0001;
        tick();
        write_cfg(0, 4, 2, 0);
        check("r_pend",  32'(pending[0]), 1);
        check("r_clock", 32'(clock[0]),   1);
        reset_n = 1'b0;
        tick();
        check("r_clock0",  32'(clock),     0);
        check("r_fall0",   32'(fall),      0);
        check("r_rise0",   32'(rise),      0);
        check("r_pend0",   32'(pending),   0);
        check("r_ready0",  32'(cfg_ready), 1);
        reset_n = 1'b1;
        tick();
        expect_wave(0, "rdef", 8, 8'b11100011, 8'b10000010, 8'b00010000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
